framebuffer_arbiter: RTL and testbench
======================================

// Module: framebuffer_arbiter
// PURPOSE
// - Shares the single-port pixel framebuffer (Memory) between three requesters:
//   VGA scan-out reads, CPU pixel reads and CPU pixel writes.
// - Sits between the CPU core, the VGA block and MemoryDevice in the ASIP top.
// - CPU writes are buffered in a small FIFO. VGA has priority.
// - A starvation guard guarantees forward progress for buffered writes.
// PARAMETERS
// - XBits       9  : pixel X coordinate width
// - YBits       8  : pixel Y coordinate width
// - ColorBits   3  : pixel colour code width
// - FifoDepth   4  : CPU write FIFO entries (power of 2, >=2)
// - StarveLimit 8  : consecutive blocked cycles before a write pre-empts VGA
// PORTS
// - clk          in   1          system clock, all logic on rising edge
// - reset        in   1          asynchronous, active-low reset
// - cpu_wr_valid in   1          CPU write request
// - cpu_wr_ready out  1          FIFO can accept (= !full, registered state)
// - cpu_wr_x     in   XBits      write X coordinate
// - cpu_wr_y     in   YBits      write Y coordinate
// - cpu_wr_color in   ColorBits  write colour
// - cpu_rd_valid in   1          CPU read request
// - cpu_rd_ready out  1          CPU read granted this cycle
// - cpu_rd_x     in   XBits      read X coordinate
// - cpu_rd_y     in   YBits      read Y coordinate
// - cpu_rd_rvalid out 1          CPU read data valid (1-cycle pulse)
// - cpu_rd_color out  ColorBits  CPU read data
// - vga_req      in   1          VGA pixel fetch; at most 1 per 2 cycles nominal
// - vga_x        in   XBits      VGA fetch X
// - vga_y        in   YBits      VGA fetch Y
// - vga_rvalid   out  1          VGA data valid (1-cycle pulse)
// - vga_color    out  ColorBits  VGA pixel data
// - vga_drop     out  1          pulse: VGA request discarded by starvation guard
// - mem_x        out  XBits      memory address X (registered)
// - mem_y        out  YBits      memory address Y (registered)
// - mem_we       out  1          memory write enable (registered)
// - mem_wdata    out  ColorBits  memory write data (registered)
// - mem_rdata    in   ColorBits  memory read data, valid 1 cycle after address
// - fifo_level   out  $clog2(FifoDepth)+1  current write FIFO occupancy
// BEHAVIOUR
// - Reset:
//   - All outputs and the FIFO are cleared. cpu_wr_ready goes 1 after reset.
//   - In-flight reads are discarded; no rvalid is issued for them.
//   - Starvation counter is set to 0.
// - Grant per cycle t is combinational on inputs plus registered state. Order:
//   1. Forced write: starve_cnt==StarveLimit and FIFO not empty.
//   2. VGA: vga_req=1.
//   3. CPU read: cpu_rd_valid=1 and FIFO empty. Empty FIFO gives read-after-write ordering.
//   4. FIFO write drain: FIFO not empty.
//   5. Idle.
// - Issue stage:
//   - Granted op appears on mem_* at t+1. mem_we=1 only for a drain.
//   - On idle cycles mem_we=0 and the address holds.
// - Read latency:
//   - mem_rdata is valid at t+2 and is captured into a tag-steered output register.
//   - vga_rvalid/cpu_rd_rvalid pulse at t+3, fixed.
//   - Back-to-back reads pipeline with 1 result per cycle.
// - cpu_rd_ready is 1 exactly in cycles where the CPU read wins. The requester holds inputs until then.
// - Write FIFO:
//   - Enqueue when cpu_wr_valid && cpu_wr_ready. No bypass: the earliest drain is the cycle after enqueue.
//   - Enqueue and dequeue in the same cycle leave the level unchanged.
//   - When full, ready=0 even if a dequeue happens that cycle.
// - Starvation guard:
//   - starve_cnt increments each cycle the FIFO is non-empty and no drain is granted.
//   - It clears on any drain and saturates at StarveLimit.
//   - A forced write pulses vga_drop at t+1 and suppresses that VGA fetch (no vga_rvalid).
// - Known limit: CPU reads can starve under continuous VGA; the system schedule guarantees gaps.
// - Coordinates are passed through unchanged. Range checking belongs to Memory.
// STRUCTURE
// - Shared package fb_pkg holds:
//   - XBits, YBits, ColorBits defaults.
//   - typedef struct pixel_wr_t {x, y, color}.
//   - enum grant_t {GNT_NONE, GNT_VGA, GNT_CPU_RD, GNT_CPU_WR}.
// - Sub-module fb_write_fifo: sync FIFO of pixel_wr_t with level/full/empty outputs.
// - Grant logic, issue registers, tag pipe and starvation counter stay in this module.
// TESTING
// 1. Reset mid-read: pull reset during an in-flight VGA read.
//    -> no vga_rvalid, fifo_level=0, mem_we=0, cpu_wr_ready=1 on release.
// 2. Single write (x=5,y=3,c=6) on an idle bus.
//    -> mem_we=1 with mem_x=5, mem_y=3, mem_wdata=6 exactly 2 cycles after the valid cycle.
// 3. Read-after-write: write (1,1,4), then cpu_rd_valid on (1,1) the next cycle.
//    -> ready held until FIFO empty, cpu_rd_color=4 with rvalid 3 cycles after ready.
// 4. VGA every 2nd cycle while 6 writes are offered.
//    -> all VGA reads return in 3 cycles, cpu_wr_ready drops at level 4, all 6 writes land.
// 5. vga_req held high 20 cycles with FIFO level 1.
//    -> forced write after 8 blocked cycles, one vga_drop pulse, no rvalid for that fetch.
// 6. Simultaneous enqueue+drain at level 2.
//    -> level stays 2, FIFO order preserved (memory contents checked by scoreboard).

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types for the framebuffer arbiter: default pixel field
//               widths, the buffered write record and the grant encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

   localparam int unsigned c_XBITS     = 9;
   localparam int unsigned c_YBITS     = 8;
   localparam int unsigned c_COLORBITS = 3;

   // One buffered CPU pixel write.
   typedef struct packed {
      logic [c_XBITS-1:0]     x;
      logic [c_YBITS-1:0]     y;
      logic [c_COLORBITS-1:0] color;
   } pixel_wr_t;

   // Owner of the memory port for one cycle. Also used as the read-return tag.
   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_VGA    = 2'd1,
      GNT_CPU_RD = 2'd2,
      GNT_CPU_WR = 2'd3
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/fb_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_fifo
// Description : Synchronous FIFO of buffered CPU pixel writes with occupancy,
//               full and empty outputs. Head entry is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_fifo
   import fb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  pixel_wr_t              push_data_i,
   input  logic                   pop_i,
   output pixel_wr_t              head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   pixel_wr_t         store_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              w_push;
   logic              w_pop;

   // Full is judged on registered occupancy only, so a same-cycle pop never
   // opens the door for a push.
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign head_o  = store_q[rd_ptr_q];
   assign level_o = level_q;

   // Occupancy next-state: simultaneous push and pop leave it unchanged.
   always_comb begin
      level_d = level_q;
      case ({w_push, w_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Entry storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         store_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_arbiter
// Description : Shares the single-port pixel framebuffer between VGA scan-out
//               reads, CPU reads and buffered CPU writes. VGA has priority; a
//               starvation guard forces a buffered write through when blocked
//               too long. Reads return data with a fixed 3-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned XBits       = c_XBITS,
   parameter int unsigned YBits       = c_YBITS,
   parameter int unsigned ColorBits   = c_COLORBITS,
   parameter int unsigned FifoDepth   = 4,
   parameter int unsigned StarveLimit = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_wr_valid,
   output logic                       cpu_wr_ready,
   input  logic [XBits-1:0]           cpu_wr_x,
   input  logic [YBits-1:0]           cpu_wr_y,
   input  logic [ColorBits-1:0]       cpu_wr_color,
   input  logic                       cpu_rd_valid,
   output logic                       cpu_rd_ready,
   input  logic [XBits-1:0]           cpu_rd_x,
   input  logic [YBits-1:0]           cpu_rd_y,
   output logic                       cpu_rd_rvalid,
   output logic [ColorBits-1:0]       cpu_rd_color,
   input  logic                       vga_req,
   input  logic [XBits-1:0]           vga_x,
   input  logic [YBits-1:0]           vga_y,
   output logic                       vga_rvalid,
   output logic [ColorBits-1:0]       vga_color,
   output logic                       vga_drop,
   output logic [XBits-1:0]           mem_x,
   output logic [YBits-1:0]           mem_y,
   output logic                       mem_we,
   output logic [ColorBits-1:0]       mem_wdata,
   input  logic [ColorBits-1:0]       mem_rdata,
   output logic [$clog2(FifoDepth):0] fifo_level
);

   localparam int unsigned STV_W = $clog2(StarveLimit + 1);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(StarveLimit);

   // Write FIFO interface. The record widths come from the package, so the
   // coordinate parameters are expected to keep their package defaults.
   pixel_wr_t                  w_wr_pix;
   pixel_wr_t                  w_head;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_pop;
   logic [$clog2(FifoDepth):0] w_level;

   // Arbitration.
   grant_t                     w_grant;
   logic                       w_force;
   logic [STV_W-1:0]           starve_q;
   logic [STV_W-1:0]           starve_d;

   // Issue registers.
   logic [XBits-1:0]           mem_x_q,     mem_x_d;
   logic [YBits-1:0]           mem_y_q,     mem_y_d;
   logic                       mem_we_q,    mem_we_d;
   logic [ColorBits-1:0]       mem_wdata_q, mem_wdata_d;

   // Read-return tag pipe: stage 1 = address on the memory bus,
   // stage 2 = memory data valid and captured at the end of the cycle.
   grant_t                     tag1_q, tag1_d;
   grant_t                     tag2_q;

   // Return registers.
   logic                       vga_rvalid_q;
   logic                       cpu_rd_rvalid_q;
   logic [ColorBits-1:0]       vga_color_q;
   logic [ColorBits-1:0]       cpu_rd_color_q;
   logic                       vga_drop_q;

   assign w_wr_pix.x     = cpu_wr_x;
   assign w_wr_pix.y     = cpu_wr_y;
   assign w_wr_pix.color = cpu_wr_color;

   fb_write_fifo #(
      .DEPTH       (FifoDepth)
   ) u_wr_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (cpu_wr_valid),
      .push_data_i (w_wr_pix),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .level_o     (w_level)
   );

   assign w_force = (starve_q == STARVE_MAX) && !w_empty;
   assign w_pop   = (w_grant == GNT_CPU_WR);

   // Fixed-priority grant: forced write, VGA, CPU read (only with an empty
   // FIFO so reads observe every earlier write), write drain, idle.
   always_comb begin
      w_grant = GNT_NONE;
      if (w_force) begin
         w_grant = GNT_CPU_WR;
      end else if (vga_req) begin
         w_grant = GNT_VGA;
      end else if (cpu_rd_valid && w_empty) begin
         w_grant = GNT_CPU_RD;
      end else if (!w_empty) begin
         w_grant = GNT_CPU_WR;
      end
   end

   // Issue next-state: the winner's address goes onto the bus next cycle; on
   // idle cycles the address holds and the write strobe drops.
   always_comb begin
      mem_x_d     = mem_x_q;
      mem_y_d     = mem_y_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      tag1_d      = GNT_NONE;
      case (w_grant)
         GNT_VGA: begin
            mem_x_d = vga_x;
            mem_y_d = vga_y;
            tag1_d  = GNT_VGA;
         end
         GNT_CPU_RD: begin
            mem_x_d = cpu_rd_x;
            mem_y_d = cpu_rd_y;
            tag1_d  = GNT_CPU_RD;
         end
         GNT_CPU_WR: begin
            mem_x_d     = w_head.x;
            mem_y_d     = w_head.y;
            mem_we_d    = 1'b1;
            mem_wdata_d = w_head.color;
         end
         default: begin
            tag1_d = GNT_NONE;
         end
      endcase
   end

   // Starvation counter next-state: counts cycles with pending writes but no
   // drain, clears on any drain, saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (w_grant == GNT_CPU_WR) begin
         starve_d = '0;
      end else if (!w_empty && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   // Issue registers and starvation counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_x_q     <= '0;
         mem_y_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         starve_q    <= '0;
      end else begin
         mem_x_q     <= mem_x_d;
         mem_y_q     <= mem_y_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         starve_q    <= starve_d;
      end
   end

   // Tag pipe and tag-steered capture of memory read data; reset discards
   // anything in flight so no stale rvalid ever appears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag1_q          <= GNT_NONE;
         tag2_q          <= GNT_NONE;
         vga_rvalid_q    <= 1'b0;
         cpu_rd_rvalid_q <= 1'b0;
         vga_color_q     <= '0;
         cpu_rd_color_q  <= '0;
         vga_drop_q      <= 1'b0;
      end else begin
         tag1_q          <= tag1_d;
         tag2_q          <= tag1_q;
         vga_rvalid_q    <= (tag2_q == GNT_VGA);
         cpu_rd_rvalid_q <= (tag2_q == GNT_CPU_RD);
         if (tag2_q == GNT_VGA) begin
            vga_color_q <= mem_rdata;
         end
         if (tag2_q == GNT_CPU_RD) begin
            cpu_rd_color_q <= mem_rdata;
         end
         vga_drop_q      <= w_force && vga_req;
      end
   end

   assign cpu_wr_ready  = !w_full;
   assign cpu_rd_ready  = (w_grant == GNT_CPU_RD);
   assign cpu_rd_rvalid = cpu_rd_rvalid_q;
   assign cpu_rd_color  = cpu_rd_color_q;
   assign vga_rvalid    = vga_rvalid_q;
   assign vga_color     = vga_color_q;
   assign vga_drop      = vga_drop_q;
   assign mem_x         = mem_x_q;
   assign mem_y         = mem_y_q;
   assign mem_we        = mem_we_q;
   assign mem_wdata     = mem_wdata_q;
   assign fifo_level    = w_level;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_arbiter
// Description : Directed self-checking bench for framebuffer_arbiter with a
//               synchronous single-port memory model on the mem_* bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_wr_valid = 1'b0;
   logic       cpu_wr_ready;
   logic [8:0] cpu_wr_x = '0;
   logic [7:0] cpu_wr_y = '0;
   logic [2:0] cpu_wr_color = '0;
   logic       cpu_rd_valid = 1'b0;
   logic       cpu_rd_ready;
   logic [8:0] cpu_rd_x = '0;
   logic [7:0] cpu_rd_y = '0;
   logic       cpu_rd_rvalid;
   logic [2:0] cpu_rd_color;
   logic       vga_req = 1'b0;
   logic [8:0] vga_x = '0;
   logic [7:0] vga_y = '0;
   logic       vga_rvalid;
   logic [2:0] vga_color;
   logic       vga_drop;
   logic [8:0] mem_x;
   logic [7:0] mem_y;
   logic       mem_we;
   logic [2:0] mem_wdata;
   logic [2:0] mem_rdata = '0;
   logic [2:0] fifo_level;

   logic [2:0] mem_arr [0:131071] = '{default: 3'd0};
   logic       vreq [0:63];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   framebuffer_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_wr_valid  (cpu_wr_valid),
      .cpu_wr_ready  (cpu_wr_ready),
      .cpu_wr_x      (cpu_wr_x),
      .cpu_wr_y      (cpu_wr_y),
      .cpu_wr_color  (cpu_wr_color),
      .cpu_rd_valid  (cpu_rd_valid),
      .cpu_rd_ready  (cpu_rd_ready),
      .cpu_rd_x      (cpu_rd_x),
      .cpu_rd_y      (cpu_rd_y),
      .cpu_rd_rvalid (cpu_rd_rvalid),
      .cpu_rd_color  (cpu_rd_color),
      .vga_req       (vga_req),
      .vga_x         (vga_x),
      .vga_y         (vga_y),
      .vga_rvalid    (vga_rvalid),
      .vga_color     (vga_color),
      .vga_drop      (vga_drop),
      .mem_x         (mem_x),
      .mem_y         (mem_y),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .fifo_level    (fifo_level)
   );

   // Single-port synchronous framebuffer: read data valid one cycle after the address.
   always @(posedge clk) begin
      if (mem_we) mem_arr[{mem_x, mem_y}] <= mem_wdata;
      mem_rdata <= mem_arr[{mem_x, mem_y}];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         wr_i;
      logic       acc;
      logic       exp_rv;
      logic [16:0] key;

      for (int i = 0; i < 64; i++) vreq[i] = 1'b0;

      // ---- Test 1: reset state, then reset during an in-flight VGA read ----
      repeat (3) step();
      reset = 1'b1;
      step(); #1;
      chk("rst_level", fifo_level, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ready", cpu_wr_ready, 1);
      chk("rst_vga_rvalid", vga_rvalid, 0);
      step();
      vga_req = 1'b1; vga_x = 9'd5; vga_y = 8'd3; #1;
      step();
      vga_req = 1'b0; #1;
      chk("t1_issue_x", mem_x, 5);
      reset = 1'b0; #1;
      chk("t1_async_clr_x", mem_x, 0);
      step();
      reset = 1'b1; #1;
      chk("t1_rel_level", fifo_level, 0);
      chk("t1_rel_mem_we", mem_we, 0);
      chk("t1_rel_wr_ready", cpu_wr_ready, 1);
      for (int k = 0; k < 5; k++) begin
         chk("t1_no_rvalid", vga_rvalid, 0);
         step(); #1;
      end

      // ---- Test 2: single write on an idle bus ----
      step();
      cpu_wr_valid = 1'b1; cpu_wr_x = 9'd5; cpu_wr_y = 8'd3; cpu_wr_color = 3'd6; #1;
      chk("t2_wr_ready", cpu_wr_ready, 1);
      step();
      cpu_wr_valid = 1'b0; #1;
      chk("t2_level1", fifo_level, 1);
      chk("t2_we_early", mem_we, 0);
      step(); #1;
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_x", mem_x, 5);
      chk("t2_mem_y", mem_y, 3);
      chk("t2_mem_wdata", mem_wdata, 6);
      chk("t2_level0", fifo_level, 0);
      step(); #1;
      chk("t2_we_off", mem_we, 0);

      // ---- Test 3: read-after-write ordering ----
      step();
      cpu_wr_valid = 1'b1; cpu_wr_x = 9'd1; cpu_wr_y = 8'd1; cpu_wr_color = 3'd4; #1;
      step();
      cpu_wr_valid = 1'b0;
      cpu_rd_valid = 1'b1; cpu_rd_x = 9'd1; cpu_rd_y = 8'd1; #1;
      chk("t3_rd_held", cpu_rd_ready, 0);
      step(); #1;
      chk("t3_rd_ready", cpu_rd_ready, 1);
      step();
      cpu_rd_valid = 1'b0; #1;
      chk("t3_rvalid_c3", cpu_rd_rvalid, 0);
      step(); #1;
      chk("t3_rvalid_c4", cpu_rd_rvalid, 0);
      step(); #1;
      chk("t3_rvalid_c5", cpu_rd_rvalid, 1);
      chk("t3_rd_color", cpu_rd_color, 4);
      step(); #1;
      chk("t3_rvalid_c6", cpu_rd_rvalid, 0);
      repeat (3) step();

      // ---- Test 4: VGA every 2nd cycle while 6 writes are offered ----
      wr_i = 0;
      for (int k = 0; k < 21; k++) begin
         step();
         vreq[k] = (k < 4) || (((k % 2) == 0) && (k < 16));
         vga_req = vreq[k]; vga_x = 9'd5; vga_y = 8'd3;
         cpu_wr_valid = (wr_i < 6);
         cpu_wr_x = 9'(10 + wr_i); cpu_wr_y = 8'd20; cpu_wr_color = 3'(wr_i + 1);
         #1;
         acc = cpu_wr_valid && cpu_wr_ready;
         if (k == 4) begin
            chk("t4_level_full", fifo_level, 4);
            chk("t4_ready_full", cpu_wr_ready, 0);
         end
         if (k == 5) chk("t4_ready_full_deq", cpu_wr_ready, 0);
         if (k == 6) chk("t4_ready_back", cpu_wr_ready, 1);
         exp_rv = (k >= 3) ? vreq[k-3] : 1'b0;
         chk("t4_vga_rvalid", vga_rvalid, exp_rv);
         if (exp_rv) chk("t4_vga_color", vga_color, 6);
         if (acc) wr_i++;
      end
      step();
      vga_req = 1'b0; cpu_wr_valid = 1'b0; #1;
      chk("t4_drained", fifo_level, 0);
      chk("t4_all_accepted", wr_i, 6);
      for (int i = 0; i < 6; i++) begin
         key = {9'(10 + i), 8'd20};
         chk("t4_mem", mem_arr[key], i + 1);
      end
      repeat (3) step();

      // ---- Test 5: VGA held 20 cycles with one buffered write ----
      for (int k = 0; k < 25; k++) begin
         step();
         vga_req = (k < 20); vga_x = 9'd5; vga_y = 8'd3;
         cpu_wr_valid = (k == 0); cpu_wr_x = 9'd7; cpu_wr_y = 8'd7; cpu_wr_color = 3'd5;
         #1;
         exp_rv = (k >= 3) && (k < 23) && (k != 12);
         chk("t5_vga_rvalid", vga_rvalid, exp_rv);
         chk("t5_vga_drop", vga_drop, (k == 10));
         chk("t5_mem_we", mem_we, (k == 10));
         if (k == 10) begin
            chk("t5_forced_x", mem_x, 7);
            chk("t5_forced_wdata", mem_wdata, 5);
         end
      end
      key = {9'd7, 8'd7};
      chk("t5_mem", mem_arr[key], 5);

      // ---- Test 6: simultaneous enqueue and drain at level 2 ----
      step();
      vga_req = 1'b1;
      cpu_wr_valid = 1'b1; cpu_wr_x = 9'd30; cpu_wr_y = 8'd40; cpu_wr_color = 3'd1; #1;
      step();
      cpu_wr_x = 9'd31; cpu_wr_color = 3'd2; #1;
      step();
      vga_req = 1'b0;
      cpu_wr_x = 9'd30; cpu_wr_color = 3'd3; #1;
      chk("t6_level_pre", fifo_level, 2);
      chk("t6_ready", cpu_wr_ready, 1);
      step();
      cpu_wr_valid = 1'b0; #1;
      chk("t6_level_hold", fifo_level, 2);
      chk("t6_we_a", mem_we, 1);
      chk("t6_wdata_a", mem_wdata, 1);
      step(); #1;
      chk("t6_wdata_b", mem_wdata, 2);
      chk("t6_x_b", mem_x, 31);
      step(); #1;
      chk("t6_wdata_c", mem_wdata, 3);
      chk("t6_x_c", mem_x, 30);
      step(); #1;
      chk("t6_level_end", fifo_level, 0);
      step(); #1;
      key = {9'd30, 8'd40};
      chk("t6_mem_ac", mem_arr[key], 3);
      key = {9'd31, 8'd40};
      chk("t6_mem_b", mem_arr[key], 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
